// File: rtl/msx_slot_mapper.sv
// MSX primary/secondary slot decoder with a four-page RAM memory mapper.
// Selects and read data are combinational; subslot and segment registers update on a single write pulse.
module msx_slot_mapper #(
   parameter logic [3:0] EXPANDED    = 4'b1000,
   parameter int         SEG_BITS    = 6,
   parameter int         RAM_SLOT    = 3,
   parameter int         RAM_SUBSLOT = 0
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [15:0]           addr_i,
   input  logic [7:0]            din_i,
   input  logic                  mreq_n_i,
   input  logic                  iorq_n_i,
   input  logic                  m1_n_i,
   input  logic                  rd_n_i,
   input  logic                  wr_n_i,
   input  logic                  rfrsh_n_i,
   input  logic [7:0]            ppi_a_i,
   output logic [3:0]            sltsl_n_o,
   output logic [15:0]           subsl_n_o,
   output logic                  ram_cs_n_o,
   output logic [SEG_BITS+13:0]  ram_a_o,
   output logic [7:0]            dout_o,
   output logic                  dout_oe_o
);

   localparam logic [1:0] RAM_SLOT_C    = 2'(RAM_SLOT);
   localparam logic [1:0] RAM_SUBSLOT_C = 2'(RAM_SUBSLOT);
   localparam logic       RAM_SLOT_EXP  = EXPANDED[RAM_SLOT];
   localparam logic [3:0][SEG_BITS-1:0] SEG_RST =
      {SEG_BITS'(0), SEG_BITS'(1), SEG_BITS'(2), SEG_BITS'(3)};

   logic [1:0]                 pg;
   logic [1:0]                 ps;
   logic [1:0]                 ss;
   logic                       ps_exp;
   logic                       mem;
   logic                       io;
   logic                       ffff_hit;
   logic                       wr_fire;
   logic [7:0]                 ssr_ps;
   logic [3:0][7:0]            ssr;
   logic [3:0][SEG_BITS-1:0]   seg_q;
   logic [3:0][SEG_BITS-1:0]   seg_d;
   logic                       wr_q;
   logic                       rst_q;

   assign pg       = addr_i[15:14];
   assign ps       = ppi_a_i[{pg, 1'b0} +: 2];
   assign ps_exp   = EXPANDED[ps];
   assign ssr_ps   = ssr[ps];
   assign ss       = ps_exp ? ssr_ps[{pg, 1'b0} +: 2] : 2'b00;
   assign mem      = ~mreq_n_i & rfrsh_n_i;
   assign io       = ~iorq_n_i & m1_n_i & (addr_i[7:2] == 6'b111111);
   assign ffff_hit = (addr_i == 16'hFFFF) & ps_exp;
   // rst_q blocks the cycle right after reset so a strobe held across reset never fires
   assign wr_fire  = ~wr_n_i & wr_q & ~rst_q;

   for (genvar n = 0; n < 4; n++) begin : g_ssr
      if (EXPANDED[n]) begin : g_exp
         logic [7:0] ssr_q;
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               ssr_q <= 8'h00;
            end else if (wr_fire && mem && ffff_hit && (ps == 2'(n))) begin
               ssr_q <= din_i;
            end
         end
         assign ssr[n] = ssr_q;
      end else begin : g_flat
         assign ssr[n] = 8'h00;
      end
   end

   always_comb begin
      seg_d = seg_q;
      if (wr_fire && io) begin
         seg_d[addr_i[1:0]] = din_i[SEG_BITS-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         seg_q <= SEG_RST;
         wr_q  <= 1'b1;
         rst_q <= 1'b1;
      end else begin
         seg_q <= seg_d;
         wr_q  <= wr_n_i;
         rst_q <= 1'b0;
      end
   end

   always_comb begin
      sltsl_n_o = 4'hF;
      subsl_n_o = 16'hFFFF;
      if (mem && !ffff_hit) begin
         sltsl_n_o[ps]       = 1'b0;
         subsl_n_o[{ps, ss}] = 1'b0;
      end
      ram_cs_n_o = ~(mem && (ps == RAM_SLOT_C) && ((ss == RAM_SUBSLOT_C) || !RAM_SLOT_EXP)
                     && !ffff_hit);
      ram_a_o    = {seg_q[pg], addr_i[13:0]};
      dout_o     = 8'hFF;
      dout_oe_o  = 1'b0;
      if (mem && ffff_hit && !rd_n_i) begin
         dout_o    = ~ssr_ps;
         dout_oe_o = 1'b1;
      end else if (io && !rd_n_i) begin
         dout_o[SEG_BITS-1:0] = seg_q[addr_i[1:0]];
         dout_oe_o            = 1'b1;
      end
   end

endmodule
